// File: rtl/captura_de_datos_multiformato.sv
// -----------------------------------------------------------------------------
// captura_de_datos_multiformato
//
// OV7670 pixel capture for the PCLK domain. Pairs of camera bytes (RGB565,
// high byte first) become one pixel. Each kept pixel is written to the
// frame-buffer DP RAM as RGB332, RGB444 or RGB565, with optional X/Y
// decimation. A frame is captured only if EN is high when VSYNC falls.
// Writes beyond DEPTH are dropped and raise OVF. A line that closes on an
// odd byte count raises LINE_ERR.
//
// Ports
//   PCLK            in   pixel clock (only clock)
//   RST             in   asynchronous active-high reset
//   VSYNC           in   vertical sync, high during vertical blanking
//   HREF            in   line valid
//   D[7:0]          in   camera data byte
//   MODE[1:0]       in   00 RGB332, 01 RGB444, 10 RGB565, 11 as RGB332
//   EN              in   capture arm, sampled at frame start
//   DP_RAM_data_in  out  pixel word, LSB-aligned
//   DP_RAM_addr_in  out  RAM write address
//   DP_RAM_regW     out  one-cycle write strobe
//   FRAME_DONE      out  one-cycle pulse at the end of a captured frame
//   OVF             out  frame produced more kept pixels than DEPTH
//   LINE_ERR        out  a line closed with a half pixel pending
//   BUSY            out  high while a frame is being captured
// -----------------------------------------------------------------------------
module captura_de_datos_multiformato #(
    parameter int AW    = 17,
    parameter int DEPTH = 19200,
    parameter int DEC_X = 1,
    parameter int DEC_Y = 1
) (
    input  logic          PCLK,
    input  logic          RST,
    input  logic          VSYNC,
    input  logic          HREF,
    input  logic [7:0]    D,
    input  logic [1:0]    MODE,
    input  logic          EN,
    output logic [15:0]   DP_RAM_data_in,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic          DP_RAM_regW,
    output logic          FRAME_DONE,
    output logic          OVF,
    output logic          LINE_ERR,
    output logic          BUSY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BLANK  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [1:0] S_SKIP   = 2'd3;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
    // Decimation factors are powers of two, so "mod" is a mask.
    localparam logic [9:0]    X_MASK  = 10'(DEC_X - 1);
    localparam logic [9:0]    Y_MASK  = 10'(DEC_Y - 1);

    // Packs the two camera bytes into the selected output format.
    function automatic logic [15:0] format_pixel(input logic [1:0] mode,
                                                 input logic [7:0] b1,
                                                 input logic [7:0] b2);
        logic [15:0] pix;
        case (mode)
            2'b01:   pix = {4'h0, b1[7:4], b1[2:0], b2[7], b2[4:1]};
            2'b10:   pix = {b1, b2};
            default: pix = {8'h00, b1[7:5], b1[2:0], b2[4:3]};
        endcase
        return pix;
    endfunction

    logic [1:0]    state_q,  state_d;
    logic          vs_q,     href_q;
    logic [1:0]    mode_q,   mode_d;
    logic          phase_q,  phase_d;
    logic [7:0]    b1_q,     b1_d;
    logic [9:0]    x_q,      x_d;
    logic [9:0]    y_q,      y_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [15:0]   data_q,   data_d;
    logic [AW-1:0] addr_q,   addr_d;
    logic          regw_q,   regw_d;
    logic          done_q,   done_d;
    logic          ovf_q,    ovf_d;
    logic          lerr_q,   lerr_d;
    logic          busy_q,   busy_d;

    logic          vs_rise, vs_fall, href_fall, keep_pix;

    assign vs_rise   = VSYNC & ~vs_q;
    assign vs_fall   = ~VSYNC & vs_q;
    assign href_fall = href_q & ~HREF;
    assign keep_pix  = ((x_q & X_MASK) == 10'd0) && ((y_q & Y_MASK) == 10'd0);

    // Next-state logic: frame sequencing, byte pairing, decimation and writes.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        phase_d  = phase_q;
        b1_d     = b1_q;
        x_d      = x_q;
        y_d      = y_q;
        wr_ptr_d = wr_ptr_q;
        data_d   = data_q;
        addr_d   = addr_q;
        regw_d   = 1'b0;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        lerr_d   = lerr_q;

        case (state_q)
            S_IDLE: begin
                // Wait for blanking so a frame already in progress is skipped.
                if (VSYNC) begin
                    state_d = S_BLANK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BLANK: begin
                if (vs_fall) begin
                    if (EN) begin
                        state_d  = S_ACTIVE;
                        mode_d   = MODE;
                        ovf_d    = 1'b0;
                        lerr_d   = 1'b0;
                        wr_ptr_d = '0;
                        x_d      = 10'd0;
                        y_d      = 10'd0;
                        phase_d  = 1'b0;
                    end else begin
                        state_d = S_SKIP;
                    end
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_ACTIVE: begin
                if (vs_rise) begin
                    // Frame end takes priority over any byte on this edge.
                    state_d = S_BLANK;
                    done_d  = 1'b1;
                end else if (HREF && !VSYNC) begin
                    if (!phase_q) begin
                        b1_d    = D;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        x_d     = x_q + 10'd1;
                        if (keep_pix) begin
                            if (wr_ptr_q < DEPTH_W) begin
                                data_d   = format_pixel(mode_q, b1_q, D);
                                addr_d   = wr_ptr_q;
                                regw_d   = 1'b1;
                                wr_ptr_d = wr_ptr_q + AW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            wr_ptr_d = wr_ptr_q;
                        end
                    end
                end else if (href_fall) begin
                    y_d = y_q + 10'd1;
                    x_d = 10'd0;
                    // A pending first byte means the line ended mid-pixel.
                    if (phase_q) begin
                        lerr_d  = 1'b1;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                    end
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            S_SKIP: begin
                if (vs_rise) begin
                    state_d = S_BLANK;
                end else begin
                    state_d = S_SKIP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ACTIVE);
    end

    // State and output registers.
    always_ff @(posedge PCLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            vs_q     <= 1'b0;
            href_q   <= 1'b0;
            mode_q   <= 2'b00;
            phase_q  <= 1'b0;
            b1_q     <= 8'h00;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            wr_ptr_q <= '0;
            data_q   <= 16'h0000;
            addr_q   <= '0;
            regw_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            lerr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            vs_q     <= VSYNC;
            href_q   <= HREF;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            b1_q     <= b1_d;
            x_q      <= x_d;
            y_q      <= y_d;
            wr_ptr_q <= wr_ptr_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            regw_q   <= regw_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            lerr_q   <= lerr_d;
            busy_q   <= busy_d;
        end
    end

    assign DP_RAM_data_in = data_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_regW    = regw_q;
    assign FRAME_DONE     = done_q;
    assign OVF            = ovf_q;
    assign LINE_ERR       = lerr_q;
    assign BUSY           = busy_q;

endmodule
